data_mem_arbiter: RTL



---
 rtl/data_mem_arbiter_if.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bundles the CPU, debug and memory signals of the data-memory arbiter.
// slave is the arbiter's view; master is the CPU/debug/memory environment.
interface data_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dbg_req;
  logic        dbg_lock;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// CPU/debug data-memory arbiter: grant and memory mux are combinational, debug read data lands 1 cycle later.
// Backpressure: CPU is stalled only in cycles the debug port is granted; starvation bounded by MAX_WAIT, bursts by MAX_BURST.
module data_mem_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  data_mem_arbiter_if.slave arb
);

  typedef enum logic {
    CPU_OWN = 1'b0,
    DBG_OWN = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LIM  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
  localparam bit         BURST_EN  = (MAX_BURST > 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [7:0]  burst_cnt, burst_cnt_nxt;
  logic [7:0]  burst_inc;
  logic        dbg_gnt;
  logic        dbg_rd;
  logic [31:0] dbg_rdata_q;
  logic        dbg_rvalid_q;

  // Debug wins when the CPU is idle, when it has waited long enough, or while it holds a locked burst.
  always_comb begin
    dbg_gnt = arb.dbg_req & (~arb.cpu_req | (wait_cnt == WAIT_LIM) |
              ((state == DBG_OWN) & arb.dbg_lock & (burst_cnt < BURST_LIM)));
    dbg_rd  = dbg_gnt & ~arb.dbg_we;
  end

  always_comb begin
    arb.mem_we    = 1'b0;
    arb.mem_addr  = arb.cpu_addr;
    arb.mem_wdata = arb.cpu_wdata;
    if (dbg_gnt) begin
      arb.mem_we    = arb.dbg_we;
      arb.mem_addr  = arb.dbg_addr;
      arb.mem_wdata = arb.dbg_wdata;
    end else if (arb.cpu_req) begin
      arb.mem_we    = arb.cpu_we;
    end
  end

  assign arb.dbg_gnt    = dbg_gnt;
  assign arb.cpu_stall  = arb.cpu_req & dbg_gnt;
  assign arb.cpu_rdata  = arb.mem_rdata;
  assign arb.dbg_rdata  = dbg_rdata_q;
  assign arb.dbg_rvalid = dbg_rvalid_q;

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    wait_cnt_nxt  = 8'd0;
    burst_inc     = burst_cnt + 8'd1;

    if (arb.dbg_req && !dbg_gnt) begin
      wait_cnt_nxt = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 8'd1;
    end

    case (state)
      CPU_OWN: begin
        if (BURST_EN && dbg_gnt && arb.dbg_lock) begin
          state_nxt     = DBG_OWN;
          burst_cnt_nxt = 8'd1;
        end
      end
      DBG_OWN: begin
        // Leaving with wait_cnt at 0 guarantees a contending CPU its next cycle.
        if (!arb.dbg_req || !arb.dbg_lock || (dbg_gnt && (burst_inc == BURST_LIM))) begin
          state_nxt     = CPU_OWN;
          burst_cnt_nxt = 8'd0;
        end else if (dbg_gnt) begin
          burst_cnt_nxt = burst_inc;
        end
      end
      default: begin
        state_nxt     = CPU_OWN;
        burst_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CPU_OWN;
      wait_cnt  <= 8'd0;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dbg_rdata_q  <= 32'h0000_0000;
      dbg_rvalid_q <= 1'b0;
    end else begin
      dbg_rvalid_q <= dbg_rd;
      if (dbg_rd) begin
        dbg_rdata_q <= arb.mem_rdata;
      end
    end
  end

endmodule
